msg_checker: RTL and testbench

Reads the decrypted-message memory produced by the RC4 decrypt loop and decides whether the candidate key produced readable plaintext. Every byte must be lowercase ASCII (8'h61–8'h7A) or space (8'h20). The block sits between the decrypt loop and the key-search controller. It is started after the decrypt loop's `finished`, drives the D-memory read address, and returns a pass/fail verdict with the address of the first offending byte.

---
 rtl/msg_checker.sv | 192 +++++++++++++++++++
 tb/tb_msg_checker.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/msg_checker.sv
// -----------------------------------------------------------------------------
// msg_checker
//
// Scans the decrypted-message memory written by the RC4 decrypt loop and
// decides whether the candidate key produced readable plaintext. A byte is
// readable when it is a lowercase ASCII letter (8'h61..8'h7A) or a space
// (8'h20). The first offending address is reported alongside the verdict.
//
// Every byte takes three cycles (READ, WAIT, CHECK). The address is held
// stable across all three, so a synchronous RAM with a registered address and
// an unregistered q has a full cycle of slack before CHECK samples the data.
//
// Optional build macro:
//   MSG_CHECKER_EARLY_EXIT_EN - when defined, the scan stops at the first
//                               illegal byte instead of reading all MSG_LEN
//                               bytes. The verdict is identical either way.
//
// Parameters:
//   MSG_LEN    number of message bytes to scan (>= 2)
//   ADDR_W     width of address_D / bad_addr, equal to $clog2(MSG_LEN)
//
// Ports:
//   clk        in   1       system clock, rising edge
//   reset_n    in   1       asynchronous active-low reset
//   start      in   1       begin a scan (only honoured in IDLE, level-sampled)
//   data_in_D  in   8       read data from the decrypted-message memory
//   address_D  out  ADDR_W  read address to the decrypted-message memory
//   busy       out  1       high while bytes are being read / checked
//   done       out  1       one-cycle pulse when the verdict is updated
//   valid      out  1       1 = every scanned byte legal, held until next done
//   bad_addr   out  ADDR_W  address of the first illegal byte, 0 when valid
// -----------------------------------------------------------------------------
module msg_checker #(
    parameter int MSG_LEN = 32,
    parameter int ADDR_W  = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        data_in_D,
    output logic [ADDR_W-1:0] address_D,
    output logic              busy,
    output logic              done,
    output logic              valid,
    output logic [ADDR_W-1:0] bad_addr
);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_CHECK = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MSG_LEN - 1);

    localparam logic [7:0] CHAR_LO    = 8'h61;  // 'a'
    localparam logic [7:0] CHAR_HI    = 8'h7A;  // 'z'
    localparam logic [7:0] CHAR_SPACE = 8'h20;  // ' '

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [2:0]        state_q,     state_d;
    logic [ADDR_W-1:0] k_q,         k_d;
    logic              fail_q,      fail_d;
    logic [ADDR_W-1:0] first_bad_q, first_bad_d;
    logic              valid_q,     valid_d;
    logic [ADDR_W-1:0] bad_addr_q,  bad_addr_d;

    // -------------------------------------------------------------------------
    // Byte classification
    // -------------------------------------------------------------------------
    logic byte_legal;
    logic stop_early;

    assign byte_legal = ((data_in_D >= CHAR_LO) && (data_in_D <= CHAR_HI)) ||
                        (data_in_D == CHAR_SPACE);

`ifdef MSG_CHECKER_EARLY_EXIT_EN
    // A single bad byte already condemns the key; no need to read the rest.
    assign stop_early = !byte_legal;
`else
    assign stop_early = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        fail_d      = fail_q;
        first_bad_d = first_bad_q;
        valid_d     = valid_q;
        bad_addr_d  = bad_addr_q;

        case (state_q)
            ST_IDLE: begin
                k_d         = '0;
                fail_d      = 1'b0;
                first_bad_d = '0;
                if (start) begin
                    state_d = ST_READ;
                end
            end

            ST_READ: begin
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                state_d = ST_CHECK;
            end

            ST_CHECK: begin
                // Only the first illegal byte is remembered.
                if (!byte_legal && !fail_q) begin
                    fail_d      = 1'b1;
                    first_bad_d = k_q;
                end

                if ((k_q == LAST_IDX) || stop_early) begin
                    state_d = ST_DONE;
                    // The verdict registers load on the edge into DONE so that
                    // they are already correct while done is high. The byte
                    // being checked right now is folded in directly because
                    // fail_q / first_bad_q have not absorbed it yet.
                    valid_d = !fail_q && byte_legal;
                    if (fail_q) begin
                        bad_addr_d = first_bad_q;
                    end else if (!byte_legal) begin
                        bad_addr_d = k_q;
                    end else begin
                        bad_addr_d = '0;
                    end
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = ST_READ;
                end
            end

            ST_DONE: begin
                state_d     = ST_IDLE;
                k_d         = '0;
                fail_d      = 1'b0;
                first_bad_d = '0;
            end

            default: begin
                state_d     = ST_IDLE;
                k_d         = '0;
                fail_d      = 1'b0;
                first_bad_d = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            fail_q      <= 1'b0;
            first_bad_q <= '0;
            valid_q     <= 1'b0;
            bad_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            fail_q      <= fail_d;
            first_bad_q <= first_bad_d;
            valid_q     <= valid_d;
            bad_addr_q  <= bad_addr_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign address_D = k_q;
    assign busy      = (state_q == ST_READ) || (state_q == ST_WAIT) ||
                       (state_q == ST_CHECK);
    assign done      = (state_q == ST_DONE);
    assign valid     = valid_q;
    assign bad_addr  = bad_addr_q;

endmodule

// File: tb/tb_msg_checker.sv
// -----------------------------------------------------------------------------
// tb_msg_checker
//
// Directed and randomized scans of msg_checker against a reference model that
// derives the verdict and timing straight from the byte rules. The memory is
// modelled as a synchronous RAM with a registered address and unregistered q.
// -----------------------------------------------------------------------------
module tb_msg_checker;

    localparam int MSG_LEN = 32;
    localparam int ADDR_W  = 5;

    logic              clk;
    logic              reset_n;
    logic              start;
    logic [7:0]        data_in_D;
    logic [ADDR_W-1:0] address_D;
    logic              busy;
    logic              done;
    logic              valid;
    logic [ADDR_W-1:0] bad_addr;

    logic [7:0]        mem [0:MSG_LEN-1];
    logic [ADDR_W-1:0] mem_addr_q;

    int tests = 0;
    int fails = 0;

    msg_checker #(
        .MSG_LEN (MSG_LEN),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .data_in_D (data_in_D),
        .address_D (address_D),
        .busy      (busy),
        .done      (done),
        .valid     (valid),
        .bad_addr  (bad_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: address registered, q combinational from it.
    always @(posedge clk) mem_addr_q <= address_D;
    assign data_in_D = mem[mem_addr_q];

    // ---------------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------------
    function automatic bit is_readable(input logic [7:0] b);
        return (b == " ") || ((b >= "a") && (b <= "z"));
    endfunction

    function automatic int model_first_bad();
        for (int i = 0; i < MSG_LEN; i++) begin
            if (!is_readable(mem[i])) return i;
        end
        return -1;
    endfunction

    function automatic int model_done_cycle(input int first_bad);
`ifdef MSG_CHECKER_EARLY_EXIT_EN
        if (first_bad >= 0) return 3 * first_bad + 4;
`endif
        return 3 * MSG_LEN + 1;
    endfunction

    // ---------------------------------------------------------------------
    // Helpers
    // ---------------------------------------------------------------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill_all(input logic [7:0] b);
        for (int i = 0; i < MSG_LEN; i++) mem[i] = b;
    endtask

    task automatic fill_text(input string s);
        for (int i = 0; i < MSG_LEN; i++) mem[i] = (i < s.len()) ? s[i] : 8'h20;
    endtask

    task automatic fill_random();
        int r;
        for (int i = 0; i < MSG_LEN; i++) begin
            r = $urandom_range(0, 26);
            mem[i] = (r == 26) ? 8'h20 : 8'(8'h61 + r);
        end
        for (int n = 0; n < 2; n++) begin
            if ($urandom_range(0, 1) == 1) mem[$urandom_range(0, MSG_LEN - 1)] = 8'($urandom);
        end
    endtask

    // One complete scan, cycle 0 being the IDLE cycle with start high.
    // Every cycle's busy/address/held-verdict is checked against the model.
    task automatic run_scan(input string tag, input bit mid_starts);
        int exp_bad, exp_done, exp_addr;
        int got_done, ndone, busy_err, addr_err, hold_err;
        logic              prev_valid;
        logic [ADDR_W-1:0] prev_bad;

        exp_bad  = model_first_bad();
        exp_done = model_done_cycle(exp_bad);
        got_done = -1;
        ndone    = 0;
        busy_err = 0;
        addr_err = 0;
        hold_err = 0;

        @(negedge clk);
        prev_valid = valid;
        prev_bad   = bad_addr;
        start      = 1'b1;

        for (int c = 1; c <= exp_done + 1; c++) begin
            @(negedge clk);
            start = mid_starts && (c == 10 || c == 50);
            if (done) begin
                ndone++;
                if (got_done < 0) got_done = c;
            end
            if (busy !== (c < exp_done)) busy_err++;
            if (c < exp_done)       exp_addr = (c - 1) / 3;
            else if (c == exp_done) exp_addr = (c - 2) / 3;
            else                    exp_addr = 0;
            if (address_D !== ADDR_W'(exp_addr)) addr_err++;
            if (c < exp_done && (valid !== prev_valid || bad_addr !== prev_bad)) hold_err++;
        end
        start = 1'b0;

        chk({tag, "/done_cycle"}, got_done, exp_done);
        chk({tag, "/done_count"}, ndone, 1);
        chk({tag, "/valid"}, valid, (exp_bad < 0));
        chk({tag, "/bad_addr"}, bad_addr, (exp_bad < 0) ? 0 : exp_bad);
        chk({tag, "/busy_errs"}, busy_err, 0);
        chk({tag, "/addr_errs"}, addr_err, 0);
        chk({tag, "/hold_errs"}, hold_err, 0);
        $display("[TB] scan %s: first_bad=%0d done@%0d valid=%0b bad_addr=%0d",
                 tag, exp_bad, got_done, valid, bad_addr);
    endtask

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    initial begin
        int ndone_rst;

        reset_n = 1'b0;
        start   = 1'b0;
        fill_all(8'h61);

        repeat (2) @(negedge clk);
        chk("reset/busy", busy, 0);
        chk("reset/done", done, 0);
        chk("reset/valid", valid, 0);
        chk("reset/bad_addr", bad_addr, 0);
        chk("reset/address", address_D, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // All-legal plaintext.
        fill_text("attack at dawn");
        run_scan("attack_at_dawn", 1'b0);

        // Boundary characters.
        fill_all(8'h61); mem[5] = 8'h7A; mem[6] = 8'h20;
        run_scan("edge_z_space", 1'b0);
        mem[9] = 8'h7B;
        run_scan("edge_7b", 1'b0);
        mem[9] = 8'h60;
        run_scan("edge_60", 1'b0);

        // Two bad bytes: only the first is reported.
        fill_all(8'h61); mem[3] = 8'h00; mem[20] = 8'hFF;
        run_scan("bad_3_20", 1'b0);

        // Failure on the very last byte.
        fill_all(8'h61); mem[31] = 8'hFF;
        run_scan("bad_last", 1'b0);

        // Stray start pulses during a scan must be ignored.
        fill_text("the quick brown fox");
        run_scan("mid_starts", 1'b1);

        // Reset in the middle of a scan (previous verdict was valid=1).
        ndone_rst = 0;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) ndone_rst++;
        end
        reset_n = 1'b0;
        #1;
        chk("midreset/busy", busy, 0);
        chk("midreset/address", address_D, 0);
        chk("midreset/valid", valid, 0);
        chk("midreset/bad_addr", bad_addr, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done) ndone_rst++;
        end
        chk("midreset/no_done", ndone_rst, 0);
        reset_n = 1'b1;
        $display("[TB] reset mid-scan: done pulses seen=%0d", ndone_rst);

        fill_text("meet me at noon");
        mem[17] = 8'h41;
        run_scan("after_reset", 1'b0);

        // Randomized messages.
        for (int t = 0; t < 8; t++) begin
            fill_random();
            run_scan($sformatf("random%0d", t), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
